// File: rtl/dma_axi_rd_burst.sv
// dma_axi_rd_burst: single-descriptor AXI4 read DMA engine.
// A descriptor (start address and word count) is split into INCR bursts of at
// most MAX_BURST beats, issued one at a time. Returned data is passed through
// to a valid/ready stream with no added latency. Protocol faults (early or
// missing rlast, SLVERR/DECERR) set a sticky error flag.
// Optional feature: define DMA_AXI_RD_4K_SPLIT_EN to also cut bursts so that
// none of them crosses a 4 KB address boundary.
module dma_axi_rd_burst #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 8,
  parameter int CNT_W     = 16,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  // descriptor and status
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  xfer_len,
  output logic              busy,
  output logic              done,
  output logic              error,
  // data stream
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  // AXI read address channel
  output logic [3:0]        m_axi_arid,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [LEN_W-1:0]  m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arlock,
  output logic [3:0]        m_axi_arcache,
  output logic [2:0]        m_axi_arprot,
  output logic [3:0]        m_axi_arqos,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  // AXI read data channel
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  localparam int BYTES = DATA_W / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam int BW    = LEN_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_reg;
  logic [ADDR_W-1:0] cur_addr_reg;
  logic [CNT_W-1:0]  words_left_reg;
  logic [BW-1:0]     beat_cnt_reg;
  logic [BW-1:0]     beats_reg;
  logic [LEN_W-1:0]  arlen_reg;
  logic              arvalid_reg;
  logic              error_reg;
  logic              drain_reg;

  logic [BW-1:0]     beats_c;
  logic              in_data;
  logic              r_fire;
  logic              at_end;
  logic              unused_rresp0;

  // Only bit 1 of rresp distinguishes a failing response.
  assign unused_rresp0 = m_axi_rresp[0];

`ifdef DMA_AXI_RD_4K_SPLIT_EN
  logic [12:0] bound_bytes;
  logic [12:0] bound_words;
  assign bound_bytes = 13'h1000 - {1'b0, cur_addr_reg[11:0]};
  assign bound_words = bound_bytes >> SIZE;
`endif

  // Size of the next burst: remaining words, capped by MAX_BURST (and 4 KB).
  always_comb begin
    beats_c = BW'(MAX_BURST);
    if (words_left_reg < CNT_W'(MAX_BURST)) begin
      beats_c = words_left_reg[BW-1:0];
    end
`ifdef DMA_AXI_RD_4K_SPLIT_EN
    if (32'(bound_words) < 32'(beats_c)) begin
      beats_c = BW'(bound_words);
    end
`endif
  end

  assign in_data = (state_reg == S_DATA);
  assign at_end  = (beat_cnt_reg == {1'b0, arlen_reg});
  // While draining a burst that overran its length, beats are swallowed.
  assign m_axi_rready = in_data && (drain_reg || m_ready);
  assign r_fire       = m_axi_rvalid && m_axi_rready;

  assign m_valid = in_data && !drain_reg && m_axi_rvalid;
  assign m_data  = m_axi_rdata;
  assign m_last  = m_valid && (words_left_reg == '0) && at_end;

  assign busy  = (state_reg == S_ADDR) || (state_reg == S_DATA);
  assign done  = (state_reg == S_DONE);
  assign error = error_reg;

  assign m_axi_arid    = 4'd0;
  assign m_axi_araddr  = cur_addr_reg;
  assign m_axi_arlen   = arlen_reg;
  assign m_axi_arsize  = 3'(SIZE);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'd2;
  assign m_axi_arprot  = 3'b010;
  assign m_axi_arqos   = 4'd0;
  assign m_axi_arvalid = arvalid_reg;

  // Descriptor acceptance, burst sequencing and R-channel beat tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      cur_addr_reg   <= '0;
      words_left_reg <= '0;
      beat_cnt_reg   <= '0;
      beats_reg      <= '0;
      arlen_reg      <= '0;
      arvalid_reg    <= 1'b0;
      error_reg      <= 1'b0;
      drain_reg      <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          state_reg <= S_IDLE;
          if (start) begin
            error_reg      <= 1'b0;
            cur_addr_reg   <= start_addr;
            words_left_reg <= xfer_len;
            state_reg      <= (xfer_len != '0) ? S_ADDR : S_DONE;
          end
        end
        S_ADDR: begin
          if (!arvalid_reg) begin
            // First cycle in ADDR: freeze the burst shape and raise arvalid.
            arvalid_reg <= 1'b1;
            beats_reg   <= beats_c;
            arlen_reg   <= LEN_W'(beats_c - BW'(1));
          end else if (m_axi_arready) begin
            arvalid_reg    <= 1'b0;
            cur_addr_reg   <= cur_addr_reg + (ADDR_W'(beats_reg) << SIZE);
            words_left_reg <= words_left_reg - CNT_W'(beats_reg);
            beat_cnt_reg   <= '0;
            drain_reg      <= 1'b0;
            state_reg      <= S_DATA;
          end
        end
        S_DATA: begin
          if (r_fire) begin
            if (m_axi_rresp[1]) begin
              error_reg <= 1'b1;
            end
            if (drain_reg) begin
              if (m_axi_rlast) begin
                drain_reg <= 1'b0;
                state_reg <= (words_left_reg != '0) ? S_ADDR : S_DONE;
              end
            end else if (m_axi_rlast) begin
              if (at_end) begin
                state_reg <= (words_left_reg != '0) ? S_ADDR : S_DONE;
              end else begin
                // Short burst: the rest of the descriptor is abandoned.
                error_reg <= 1'b1;
                state_reg <= S_DONE;
              end
            end else if (at_end) begin
              // Expected last beat came without rlast: swallow until it shows.
              error_reg <= 1'b1;
              drain_reg <= 1'b1;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + BW'(1);
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_axi_rd_burst.sv
// Bench for dma_axi_rd_burst: a randomized AXI read slave feeds the DUT while a
// monitor logs AR requests, stream beats and done/error. Each transfer is
// compared with a reference built from start address and length alone.
module tb_dma_axi_rd_burst;

  localparam int ADDR_W = 32, DATA_W = 32, LEN_W = 8, CNT_W = 16, MAX_BURST = 16;

  logic clk, rst, start, busy, done, error;
  logic [ADDR_W-1:0] start_addr;
  logic [CNT_W-1:0] xfer_len;
  logic m_valid, m_ready, m_last;
  logic [DATA_W-1:0] m_data;
  logic [3:0] m_axi_arid, m_axi_arcache, m_axi_arqos;
  logic [ADDR_W-1:0] m_axi_araddr;
  logic [LEN_W-1:0] m_axi_arlen;
  logic [2:0] m_axi_arsize, m_axi_arprot;
  logic [1:0] m_axi_arburst, m_axi_rresp;
  logic m_axi_arlock, m_axi_arvalid, m_axi_arready;
  logic [DATA_W-1:0] m_axi_rdata;
  logic m_axi_rlast, m_axi_rvalid, m_axi_rready;

  dma_axi_rd_burst #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
                     .CNT_W(CNT_W), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .xfer_len(xfer_len), .busy(busy), .done(done), .error(error),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arqos(m_axi_arqos), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Slave fault controls and monitor logs.
  logic [31:0] salt;
  int  err_beat = -1, early_beat = 0, miss_burst = -1, miss_extra = 2;
  bit  bp_mode = 0;
  int  cyc = 0, done_cnt = 0, done_cyc = -1, last_rlast_cyc = -1, start_cyc = -1;
  int  mirror_viol = 0, const_viol = 0;
  bit  busy_seen = 0;
  logic err_at_done = 1'b0;
  logic [31:0] ar_addr_log[$];
  int          ar_len_log[$];
  logic [31:0] out_q[$];
  bit          last_q[$];
  logic [31:0] sq_addr[$];
  int          sq_len[$];
  logic [31:0] rb_data[$];
  bit          rb_last[$];
  logic [1:0]  rb_resp[$];
  int  burst_n = 0, gbeat = 0;
  bit  r_hs = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // AXI slave plus monitor: sample at negedge, drive just after posedge.
  initial begin : bus_model
    forever begin
      @(negedge clk);
      cyc++;
      r_hs = 0;
      if (!rst) begin
        if (m_axi_arvalid && m_axi_arready) begin
          sq_addr.push_back(m_axi_araddr);
          sq_len.push_back(int'(m_axi_arlen));
          ar_addr_log.push_back(m_axi_araddr);
          ar_len_log.push_back(int'(m_axi_arlen));
          if (m_axi_arsize !== 3'd2 || m_axi_arburst !== 2'b01 || m_axi_arcache !== 4'd2 ||
              m_axi_arprot !== 3'b010 || m_axi_arid !== 4'd0 || m_axi_arlock !== 1'b0 ||
              m_axi_arqos !== 4'd0)
            const_viol++;
        end
        r_hs = m_axi_rvalid && m_axi_rready;
        if (r_hs && m_axi_rlast) last_rlast_cyc = cyc;
        if (m_valid && m_ready) begin
          out_q.push_back(m_data);
          last_q.push_back(m_last);
        end
        if (m_valid && (m_axi_rready !== m_ready || m_data !== m_axi_rdata)) mirror_viol++;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          err_at_done = error;
        end
        if (busy) busy_seen = 1;
        if (start && start_cyc < 0) start_cyc = cyc;
      end
      @(posedge clk);
      #1;
      if (rst) begin
        sq_addr.delete(); sq_len.delete();
        rb_data.delete(); rb_last.delete(); rb_resp.delete();
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_arready = 1'b0;
      end else begin
        m_axi_arready = ($urandom_range(0, 2) != 0);
        m_ready = bp_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (r_hs) begin
          void'(rb_data.pop_front()); void'(rb_last.pop_front()); void'(rb_resp.pop_front());
        end
        if (rb_data.size() == 0 && sq_addr.size() != 0) begin
          logic [31:0] a;
          int n, nb;
          a = sq_addr.pop_front();
          n = sq_len.pop_front() + 1;
          nb = (burst_n == 0 && early_beat > 0) ? early_beat : n;
          for (int i = 0; i < nb; i++) begin
            rb_data.push_back((a + 32'(4 * i)) ^ salt);
            rb_resp.push_back((gbeat + i == err_beat) ? 2'b10 : 2'b00);
            rb_last.push_back(i == nb - 1 && burst_n != miss_burst);
          end
          if (burst_n == miss_burst) begin
            for (int j = 0; j < miss_extra; j++) begin
              rb_data.push_back(32'hDEAD_0000 + 32'(j));
              rb_resp.push_back(2'b00);
              rb_last.push_back(j == miss_extra - 1);
            end
          end
          gbeat += n;
          burst_n++;
        end
        if (rb_data.size() != 0) begin
          if (!m_axi_rvalid || r_hs) m_axi_rvalid = ($urandom_range(0, 3) != 0);
          m_axi_rdata = rb_data[0];
          m_axi_rlast = rb_last[0];
          m_axi_rresp = rb_resp[0];
        end else begin
          m_axi_rvalid = 1'b0;
          m_axi_rlast  = 1'b0;
        end
      end
    end
  end

  task automatic arm(input bit bp, input int eb, input int early, input int miss);
    ar_addr_log.delete(); ar_len_log.delete(); out_q.delete(); last_q.delete();
    salt = $urandom;
    err_beat = eb; early_beat = early; miss_burst = miss; bp_mode = bp;
    burst_n = 0; gbeat = 0;
    done_cnt = 0; done_cyc = -1; last_rlast_cyc = -1; start_cyc = -1;
    busy_seen = 0; mirror_viol = 0; const_viol = 0; err_at_done = 1'b0;
  endtask

  task automatic run_xfer(input string tag, input logic [31:0] addr, input int len,
                          input bit bp, input int eb, input int early, input int miss,
                          input bit poke);
    logic [31:0] exp_addr[$];
    int exp_len[$];
    logic [31:0] a;
    int left, b, off, exp_beats, waited, n;
    // Reference: walk the descriptor, cutting bursts by count (and 4 KB).
    a = addr; left = len;
    while (left > 0) begin
      b = (left < MAX_BURST) ? left : MAX_BURST;
`ifdef DMA_AXI_RD_4K_SPLIT_EN
      off = int'(a[11:0]);
      if ((4096 - off) / 4 < b) b = (4096 - off) / 4;
`else
      off = 0;
`endif
      exp_addr.push_back(a);
      exp_len.push_back(b - 1 + off * 0);
      a = a + 32'(4 * b);
      left -= b;
    end
    if (early > 0) begin
      while (exp_addr.size() > 1) begin
        void'(exp_addr.pop_back()); void'(exp_len.pop_back());
      end
      exp_beats = early;
    end else begin
      exp_beats = len;
    end
    arm(bp, eb, early, miss);
    @(posedge clk); #2;
    start = 1'b1; start_addr = addr; xfer_len = CNT_W'(len);
    @(posedge clk); #2;
    start = 1'b0;
    if (poke) begin
      repeat (3) @(posedge clk);
      #2;
      chk({tag, " busy_at_poke"}, 64'(busy), 64'd1);
      start = 1'b1; start_addr = 32'h0000_8000; xfer_len = 16'd3;
      @(posedge clk); #2;
      start = 1'b0;
    end
    waited = 0;
    while (done_cnt == 0 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    repeat (6) @(negedge clk);
    chk({tag, " done_count"}, 64'(done_cnt), 64'd1);
    chk({tag, " ar_count"}, 64'(ar_addr_log.size()), 64'(exp_addr.size()));
    n = (ar_addr_log.size() < exp_addr.size()) ? ar_addr_log.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s araddr[%0d]", tag, i), 64'(ar_addr_log[i]), 64'(exp_addr[i]));
      chk($sformatf("%s arlen[%0d]", tag, i), 64'(ar_len_log[i]), 64'(exp_len[i]));
    end
    chk({tag, " ar_const"}, 64'(const_viol), 64'd0);
    chk({tag, " passthru"}, 64'(mirror_viol), 64'd0);
    chk({tag, " beat_count"}, 64'(out_q.size()), 64'(exp_beats));
    n = (out_q.size() < exp_beats) ? out_q.size() : exp_beats;
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s data[%0d]", tag, k), 64'(out_q[k]), 64'((addr + 32'(4 * k)) ^ salt));
      chk($sformatf("%s last[%0d]", tag, k), 64'(last_q[k]), 64'(early == 0 && k == len - 1));
    end
    chk({tag, " error"}, 64'(err_at_done), 64'(eb >= 0 || early > 0 || miss >= 0));
    if (len > 0) begin
      chk({tag, " done_latency"}, 64'(done_cyc - last_rlast_cyc), 64'd1);
    end else begin
      chk({tag, " zero_latency"}, 64'(done_cyc - start_cyc), 64'd1);
      chk({tag, " zero_busy"}, 64'(busy_seen), 64'd0);
    end
    chk({tag, " idle_after"}, 64'(busy), 64'd0);
    $display("xfer %s addr=0x%08h len=%0d ars=%0d beats=%0d error=%0b",
             tag, addr, len, ar_addr_log.size(), out_q.size(), err_at_done);
  endtask

  initial begin : stimulus
    logic [31:0] r;
    int w;
    rst = 1'b1; start = 1'b0; start_addr = '0; xfer_len = '0; m_ready = 1'b1;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
    m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
    repeat (3) @(posedge clk);
    #2;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst error", 64'(error), 64'd0);
    chk("rst arvalid", 64'(m_axi_arvalid), 64'd0);
    chk("rst rready", 64'(m_axi_rready), 64'd0);
    chk("rst m_valid", 64'(m_valid), 64'd0);
    chk("arsize", 64'(m_axi_arsize), 64'd2);
    rst = 1'b0;

    run_xfer("single",       32'h0000_1000,  5, 0, -1, 0, -1, 0);
    run_xfer("multi",        32'h0000_0000, 40, 0, -1, 0, -1, 0);
    run_xfer("boundary4k",   32'h0000_0FF8,  8, 0, -1, 0, -1, 0);
    r = $urandom;
    run_xfer("backpressure", {16'h0, r[15:2], 2'b00}, 40, 1, -1, 0, -1, 0);
    run_xfer("rresp_err",    32'h0000_2000,  5, 0,  2, 0, -1, 0);
    run_xfer("early_rlast",  32'h0000_3000, 20, 0, -1, 2, -1, 0);
    run_xfer("miss_rlast",   32'h0000_4000, 20, 1, -1, 0,  0, 0);
    run_xfer("after_err",    32'h0000_5000,  7, 0, -1, 0, -1, 0);
    run_xfer("busy_start",   32'h0000_6000, 40, 0, -1, 0, -1, 1);
    run_xfer("zero_len",     32'h0000_7000,  0, 0, -1, 0, -1, 0);

    // Reset in the middle of a transfer must drop everything at once.
    arm(0, -1, 0, -1);
    @(posedge clk); #2;
    start = 1'b1; start_addr = 32'h0000_9000; xfer_len = 16'd40;
    @(posedge clk); #2;
    start = 1'b0;
    w = 0;
    while (out_q.size() < 3 && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk("midrst progress", 64'(out_q.size() >= 3), 64'd1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("midrst arvalid", 64'(m_axi_arvalid), 64'd0);
    chk("midrst rready", 64'(m_axi_rready), 64'd0);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst m_valid", 64'(m_valid), 64'd0);
    $display("xfer midrst addr=0x00009000 len=40 beats_before_reset=%0d", out_q.size());
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    run_xfer("post_reset",   32'h0000_1000,  5, 0, -1, 0, -1, 0);

    for (int t = 0; t < 4; t++) begin
      r = $urandom;
      run_xfer($sformatf("random%0d", t), {16'h0, r[15:2], 2'b00},
               int'($urandom_range(1, 50)), r[16], -1, 0, -1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
